tc_7seg_scan: RTL and testbench
===============================

# tc_7seg_scan

Parametrised two's-complement to multiplexed 7-segment display driver. It converts a WIDTH-bit signed value to sign plus decimal magnitude with a sequential shift-add-3 (double-dabble) converter, blanks leading zeros, and time-multiplexes DIGITS magnitude digits plus one sign digit onto a single shared segment bus. It sits between datapath results and the board's common-anode display bank, and replaces per-digit combinational decoders for values wider than one hex digit.

## Interface

- WIDTH, 8: input width in bits, two's complement; minimum 2.
- DIGITS, 3: number of decimal magnitude digits. Must satisfy 10^DIGITS > 2^(WIDTH-1).
- SCAN_DIV, 50000: number of Clock cycles each digit stays active; minimum 1.

- Clock  in  1  single clock. All state changes on the rising edge.
- Reset  in  1  synchronous, active-high.
- Load  in  1  strobe that requests conversion of N.
- N  in  WIDTH  two's-complement value, sampled on an accepted Load.
- Busy  out  1  conversion in progress; Load is ignored while high.
- Valid  out  1  one-cycle pulse when the display registers update.
- Seg  out  7  {g,f,e,d,c,b,a}, active-low, pattern for the currently selected digit.
- An  out  DIGITS+1  active-low one-hot digit select. Bit 0 is the ones digit, bit DIGITS-1 is the most significant magnitude digit, and bit DIGITS is the sign.

## Operation

- FSM states:
  - IDLE: Load=1 captures N, computes magnitude and sign, clears the BCD shift register, and moves to CONV.
  - CONV: WIDTH iterations, one per cycle. Each iteration adds 3 to every BCD nibble >= 5, then shifts the magnitude MSB into the BCD LSB. After iteration WIDTH the FSM moves to DONE.
  - DONE: latches BCD digits and sign into the display registers, pulses Valid, and returns to IDLE. Load is ignored in DONE.
- Sign: neg = N[WIDTH-1]. Magnitude = neg ? -N : N, computed in WIDTH bits unsigned. For N = -2^(WIDTH-1) the magnitude is 2^(WIDTH-1), which must display correctly (no overflow).
- Zero: always non-negative. The sign digit is blank.
- Leading-zero blanking:
  - Magnitude digit i is blank if it and all digits above it are 0, except digit 0, which always shows.
  - The sign digit shows minus (7'b0111111) when neg=1, otherwise blank (7'b1111111).
- Digit patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Scan:
  - A divider counts 0..SCAN_DIV-1. On wrap, the scan index advances 0, 1, ..., DIGITS, then back to 0.
  - An = ~(1 << index).
  - Seg is combinational from the scan index and the display registers.
- The display holds the previous result for the whole conversion. Scanning never pauses.

## Timing

- Reset values:
  - FSM IDLE, Busy=0, Valid=0, divider=0, scan index=0.
  - Display registers hold value 0, non-negative.
  - Therefore An = all ones except bit 0 low, and Seg = 7'b1000000.
- Latency:
  - Load accepted at edge t. Busy=1 after edge t.
  - CONV iterations occur at edges t+1..t+WIDTH.
  - At edge t+WIDTH+1: display registers update, Valid=1 for exactly one cycle, Busy=0.
- Throughput: a new Load is accepted in the cycle Valid is high (FSM is IDLE). Back-to-back conversions therefore take WIDTH+2 cycles each.
- A Load while Busy=1 is dropped, not queued. N changing during conversion has no effect.
- Reset mid-conversion: takes priority over everything. It aborts the conversion and restores all reset values, so the display returns to "0". Valid is not pulsed.
- SCAN_DIV=1: the index advances every cycle.

## Test plan

Parameters for all scenarios: WIDTH=8, DIGITS=3, SCAN_DIV=4.

1. Reset held 2 cycles, then released -> Busy=0, Valid=0, An=4'b1110, Seg=7'b1000000. Over 16 cycles An steps 1110→1101→1011→0111 every 4 cycles and wraps to 1110. Seg is blank (1111111) on indices 1–3.
2. Load with N=8'h7F (127) -> Busy for 9 cycles. Valid pulses exactly 9 edges after the Load edge. Displayed digits: sign blank, then 1, 2, 7 (ones=1111000).
3. Load with N=8'h80 (-128) -> sign digit 0111111, magnitude digits 1, 2, 8. No overflow.
4. Load with N=8'hFF (-1) -> sign minus, hundreds and tens blank, ones=1111001. Then Load N=8'h00 -> sign blank and ones=1000000 (no "-0").
5. Load N=8'h2A, then assert Load with N=8'h05 three cycles later while Busy -> the second request is ignored and the display shows 4, 2 with hundreds blank. A Load of N=8'h05 issued in the Valid cycle is accepted and shows 5 after 9 more edges.
6. Load N=8'h64 (100), then assert Reset 4 cycles into CONV -> Valid never pulses, Busy=0 the cycle after Reset, and the display shows "0" with An=4'b1110.

Source files
------------

// File: rtl/tc_7seg_scan.sv
// Signed binary to multiplexed common-anode 7-segment driver: sequential
// double-dabble conversion, leading-zero blanking and a free-running digit scan.
module tc_7seg_scan #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DIGITS   = 3,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic [WIDTH-1:0]  i_n,
    output logic              o_busy,
    output logic              o_valid,
    output logic [6:0]        o_seg_c,
    output logic [DIGITS:0]   o_an
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_valid;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_mag;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_neg;
    logic [BCD_W-1:0]   r_disp_bcd;
    logic               r_disp_neg;
    logic [DIV_W-1:0]   r_div;
    logic [IDX_W-1:0]   r_idx;
    logic [DIGITS:0]    r_an;

    logic [WIDTH-1:0]   w_mag_in;
    logic [BCD_W-1:0]   w_bcd_nxt;
    logic [3:0]         w_nib;
    logic               w_carry;
    logic [3:0]         w_disp_nib;
    logic               w_upper_zero;
    logic [6:0]         w_seg;

    // Magnitude in WIDTH unsigned bits; -2^(WIDTH-1) maps to 2^(WIDTH-1) cleanly.
    assign w_mag_in = i_n[WIDTH-1] ? WIDTH'(-i_n) : i_n;

    // One double-dabble step: add-3 on each nibble >= 5, then shift in the magnitude MSB.
    always_comb begin
        w_bcd_nxt = '0;
        w_nib     = '0;
        w_carry   = r_mag[WIDTH-1];
        for (int i = 0; i < int'(DIGITS); i++) begin
            w_nib = r_bcd[4*i +: 4];
            if (w_nib >= 4'd5) begin
                w_nib = w_nib + 4'd3;
            end
            w_bcd_nxt[4*i +: 4] = {w_nib[2:0], w_carry};
            w_carry = w_nib[3];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_cnt      <= '0;
            r_mag      <= '0;
            r_bcd      <= '0;
            r_neg      <= 1'b0;
            r_disp_bcd <= '0;
            r_disp_neg <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_load) begin
                        r_mag   <= w_mag_in;
                        r_neg   <= i_n[WIDTH-1];
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_bcd <= w_bcd_nxt;
                    r_mag <= r_mag << 1;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_disp_bcd <= r_bcd;
                    r_disp_neg <= r_neg;
                    r_valid    <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Scan divider; the anode select rotates its single zero in step with the index.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div <= '0;
            r_idx <= '0;
            r_an  <= {{DIGITS{1'b1}}, 1'b0};
        end else if (r_div == DIV_W'(SCAN_DIV - 1)) begin
            r_div <= '0;
            r_idx <= (r_idx == IDX_W'(DIGITS)) ? '0 : r_idx + IDX_W'(1);
            r_an  <= {r_an[DIGITS-1:0], r_an[DIGITS]};
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    // Walk digits from the top so each one knows whether everything above it is zero.
    always_comb begin
        w_seg        = 7'b1111111;
        w_upper_zero = 1'b1;
        w_disp_nib   = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            w_disp_nib   = r_disp_bcd[4*i +: 4];
            w_upper_zero = w_upper_zero && (w_disp_nib == 4'd0);
            if ((r_idx == IDX_W'(i)) && (!w_upper_zero || (i == 0))) begin
                w_seg = seg_of(w_disp_nib);
            end
        end
        if (r_idx == IDX_W'(DIGITS)) begin
            w_seg = r_disp_neg ? 7'b0111111 : 7'b1111111;
        end
    end

    assign o_busy  = r_busy;
    assign o_valid = r_valid;
    assign o_an    = r_an;
    assign o_seg_c = w_seg;

endmodule

// File: tb/tb_tc_7seg_scan.sv
// Bench for tc_7seg_scan: vector table with a scoreboard queue of expected
// display patterns, plus reset, dropped-load, back-to-back and abort sequences.
module tb_tc_7seg_scan;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned DIGITS   = 3;
    localparam int unsigned SCAN_DIV = 4;
    localparam int          LAT      = WIDTH + 1;

    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P1 = 7'b1111001;
    localparam logic [6:0] P2 = 7'b0100100;
    localparam logic [6:0] P3 = 7'b0110000;
    localparam logic [6:0] P4 = 7'b0011001;
    localparam logic [6:0] P5 = 7'b0010010;
    localparam logic [6:0] P6 = 7'b0000010;
    localparam logic [6:0] P7 = 7'b1111000;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0010000;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] MI = 7'b0111111;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [7:0] n;
    logic       busy;
    logic       valid;
    logic [6:0] seg;
    logic [3:0] an;

    tc_7seg_scan #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_load  (load),
        .i_n     (n),
        .o_busy  (busy),
        .o_valid (valid),
        .o_seg_c (seg),
        .o_an    (an)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Display patterns indexed {sign, hundreds, tens, ones}
    typedef struct packed {
        logic [7:0]      n;
        logic [3:0][6:0] seg;
    } vec_t;

    typedef struct packed {
        logic [3:0][6:0] seg;
        int              load_cyc;
    } sb_t;

    int              errors = 0;
    int              checks = 0;
    sb_t             sb_q[$];
    logic [3:0][6:0] shown;
    vec_t            vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int an_idx(input logic [3:0] a);
        case (a)
            4'b1110: an_idx = 0;
            4'b1101: an_idx = 1;
            4'b1011: an_idx = 2;
            4'b0111: an_idx = 3;
            default: an_idx = -1;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the load edge.
    task automatic drive_load(input logic [7:0] v, input logic [3:0][6:0] exp, input bit push);
        sb_t e;
        load = 1'b1;
        n    = v;
        @(negedge clk);
        load = 1'b0;
        n    = $urandom_range(255, 0);
        chk("busy_after_load", busy, 1);
        if (push) begin
            e.seg      = exp;
            e.load_cyc = cyc;
            sb_q.push_back(e);
        end
    endtask

    // Waits for Valid, checking the old display is held meanwhile, then scores the result.
    task automatic wait_valid();
        int k = 0;
        int idx;
        sb_t e;
        while (!valid && k < 20) begin
            idx = an_idx(an);
            if (busy && idx >= 0) chk("hold_during_conv", seg, shown[idx]);
            @(negedge clk);
            k++;
        end
        if (!valid) begin
            chk("valid_timeout", valid, 1);
        end else if (sb_q.size() == 0) begin
            chk("unexpected_valid", valid, 0);
        end else begin
            e = sb_q.pop_front();
            chk("latency", cyc - e.load_cyc, LAT);
            chk("busy_at_valid", busy, 0);
            shown = e.seg;
        end
    endtask

    // Observes one full scan period and compares each digit position once.
    task automatic check_display();
        bit [3:0] seen = '0;
        int idx;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0) chk("valid_one_cycle", valid, 0);
            idx = an_idx(an);
            if (idx < 0) begin
                chk("an_onehot", an, 4'b1110);
            end else if (!seen[idx]) begin
                seen[idx] = 1'b1;
                chk($sformatf("digit%0d", idx), seg, shown[idx]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (!seen[i]) chk($sformatf("scan_reached%0d", i), 0, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_an;
        int         exp_idx;
        int         vcount;

        vecs[0]  = '{8'h7F, {BL, P1, P2, P7}};
        vecs[1]  = '{8'h80, {MI, P1, P2, P8}};
        vecs[2]  = '{8'hFF, {MI, BL, BL, P1}};
        vecs[3]  = '{8'h00, {BL, BL, BL, P0}};
        vecs[4]  = '{8'h0A, {BL, BL, P1, P0}};
        vecs[5]  = '{8'h9C, {MI, P1, P0, P0}};
        vecs[6]  = '{8'h64, {BL, P1, P0, P0}};
        vecs[7]  = '{8'h63, {BL, BL, P9, P9}};
        vecs[8]  = '{8'hC9, {MI, BL, P5, P5}};
        vecs[9]  = '{8'h81, {MI, P1, P2, P7}};
        vecs[10] = '{8'h24, {BL, BL, P3, P6}};

        rst  = 1'b1;
        load = 1'b0;
        n    = '0;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        shown = {BL, BL, BL, P0};

        // Reset state and free-running scan
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        for (int k = 0; k <= 16; k++) begin
            exp_idx = (k / 4) % 4;
            exp_an  = ~(4'b0001 << exp_idx);
            chk($sformatf("rst_an_k%0d", k), an, exp_an);
            chk($sformatf("rst_seg_k%0d", k), seg, (exp_idx == 0) ? P0 : BL);
            @(negedge clk);
        end

        // Vector table
        for (int i = 0; i < 11; i++) begin
            drive_load(vecs[i].n, vecs[i].seg, 1'b1);
            wait_valid();
            check_display();
        end

        // Load while busy is dropped
        drive_load(8'h2A, {BL, BL, P4, P2}, 1'b1);
        repeat (2) @(negedge clk);
        load = 1'b1;
        n    = 8'h05;
        @(negedge clk);
        load = 1'b0;
        wait_valid();
        check_display();

        // Load in the Valid cycle is accepted
        drive_load(8'h2A, {BL, BL, P4, P2}, 1'b1);
        wait_valid();
        drive_load(8'h05, {BL, BL, BL, P5}, 1'b1);
        wait_valid();
        check_display();

        // Reset mid-conversion aborts and restores "0"
        drive_load(8'h64, {BL, P1, P0, P0}, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", valid, 0);
        chk("abort_an", an, 4'b1110);
        chk("abort_seg", seg, P0);
        vcount = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (valid) vcount++;
        end
        chk("abort_no_valid", vcount, 0);
        shown = {BL, BL, BL, P0};
        check_display();

        chk("scoreboard_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
